// File: rtl/cook_timer_ctrl.sv
// Microwave cook-timer controller: keypad M:SS entry, per-second countdown,
// pause/resume/clear, door interlock and DONE hold, all outputs registered.
module cook_timer_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int DONE_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       mag_on,
  output logic       done,
  output logic       busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(DONE_HOLD + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, next_state;
  logic [PW-1:0] presc, next_presc;
  logic [HW-1:0] hold_cnt, next_hold;
  logic [3:0]    next_ones, next_tens, next_min;
  logic [3:0]    dec_ones, dec_tens, dec_min;
  logic          wrap, dec_zero;
  logic          mag_on_d, done_d, busy_d;

  assign wrap     = (presc == PRESC_MAX);
  assign dec_ones = (sec_ones != 4'd0) ? sec_ones - 4'd1 : 4'd9;
  assign dec_tens = (sec_ones != 4'd0) ? sec_tens :
                    ((sec_tens != 4'd0) ? sec_tens - 4'd1 : 4'd5);
  assign dec_min  = (sec_ones == 4'd0 && sec_tens == 4'd0) ? min - 4'd1 : min;
  assign dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_min == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      hold_cnt <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min      <= 4'd0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      presc    <= next_presc;
      hold_cnt <= next_hold;
      sec_ones <= next_ones;
      sec_tens <= next_tens;
      min      <= next_min;
      mag_on   <= mag_on_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

  // Events are resolved in priority order stop > door open > start > key.
  always_comb begin
    next_state = state;
    next_presc = presc;
    next_hold  = hold_cnt;
    next_ones  = sec_ones;
    next_tens  = sec_tens;
    next_min   = min;
    case (state)
      IDLE: begin
        if (stop) begin
          next_ones = 4'd0;
          next_tens = 4'd0;
          next_min  = 4'd0;
        end else if (!door_closed) begin
          next_state = IDLE;
        end else if (start) begin
          if (sec_ones != 4'd0 || sec_tens != 4'd0 || min != 4'd0) begin
            next_state = RUN;
            next_presc = '0;
          end
        end else if (key_valid && key_digit <= 4'd9 && sec_ones <= 4'd5) begin
          next_min  = sec_tens;
          next_tens = sec_ones;
          next_ones = key_digit;
        end
      end
      RUN: begin
        // Pausing holds the prescaler so a resume continues the partial second.
        if (stop || !door_closed) begin
          next_state = PAUSE;
        end else begin
          next_presc = wrap ? '0 : presc + 1'b1;
          if (wrap) begin
            next_ones = dec_ones;
            next_tens = dec_tens;
            next_min  = dec_min;
            if (dec_zero) begin
              next_state = DONE;
              next_hold  = '0;
            end
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          next_state = IDLE;
          next_ones  = 4'd0;
          next_tens  = 4'd0;
          next_min   = 4'd0;
        end else if (door_closed && start) begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (stop || (door_closed && start)) begin
          next_state = IDLE;
          next_presc = '0;
        end else begin
          next_presc = wrap ? '0 : presc + 1'b1;
          if (wrap) begin
            if (hold_cnt == HOLD_LAST) next_state = IDLE;
            else next_hold = hold_cnt + 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mag_on_d = (next_state == RUN);
    done_d   = (next_state == DONE);
    busy_d   = (next_state == RUN) || (next_state == PAUSE);
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [3:0] sec_ones, sec_tens, min;
  logic       mag_on, done, busy;

  typedef struct {
    string      name;
    logic [14:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cook_timer_ctrl #(.TICK_DIV(4), .DONE_HOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min(min),
    .mag_on(mag_on), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation is consumed per falling edge, {min,tens,ones,mag,done,busy}.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = exp_q.pop_front();
      act = {min, sec_tens, sec_ones, mag_on, done, busy};
      checks++;
      if (act !== e.value) begin
        errors++;
        $display("[TB] FAIL %s: got %0h:%0h%0h mag=%b done=%b busy=%b, expected %0h:%0h%0h mag=%b done=%b busy=%b",
                 e.name, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                 e.value[14:11], e.value[10:7], e.value[6:3], e.value[2], e.value[1], e.value[0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic apply_stimulus(input logic kv, input logic [3:0] kd, input logic st,
                                input logic sp, input logic dc);
    key_valid   = kv;
    key_digit   = kd;
    start       = st;
    stop        = sp;
    door_closed = dc;
    next_cycle();
    key_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_output(input string name, input logic [3:0] m, input logic [3:0] t,
                              input logic [3:0] o, input logic mg, input logic dn,
                              input logic bz);
    exp_t e;
    e.name  = name;
    e.value = {m, t, o, mg, dn, bz};
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_closed = 1'b1;
    idle_cycles(2);
    check_output("reset", 0, 0, 0, 0, 0, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Digit entry shifts left, one cycle after each strobe
    press_key(4'd1); check_output("key1", 0, 0, 1, 0, 0, 0);
    press_key(4'd3); check_output("key3", 0, 1, 3, 0, 0, 0);
    press_key(4'd0); check_output("key0", 1, 3, 0, 0, 0, 0);

    apply_stimulus(0, 0, 0, 1, 1); check_output("idle_stop_clear", 0, 0, 0, 0, 0, 0);
    press_key(4'd7); check_output("key7", 0, 0, 7, 0, 0, 0);
    press_key(4'd8); check_output("key8_rejected", 0, 0, 7, 0, 0, 0);
    press_key(4'd12); check_output("key12_ignored", 0, 0, 7, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0); check_output("start_door_open", 0, 0, 7, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 1); check_output("clear_again", 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1); check_output("start_zero", 0, 0, 0, 0, 0, 0);

    // Countdown from 1:00 with TICK_DIV=4
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    check_output("entry_100", 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1); check_output("run_start", 1, 0, 0, 1, 0, 1);
    idle_cycles(3); check_output("run_before_tick", 1, 0, 0, 1, 0, 1);
    idle_cycles(1); check_output("run_059", 0, 5, 9, 1, 0, 1);
    idle_cycles(4); check_output("run_058", 0, 5, 8, 1, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1); check_output("pause_058", 0, 5, 8, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1); check_output("pause_clear", 0, 0, 0, 0, 0, 0);

    // Door opens on the wrap cycle, then resume and finish
    press_key(4'd2); check_output("entry_002", 0, 0, 2, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1); check_output("run_002", 0, 0, 2, 1, 0, 1);
    idle_cycles(3); check_output("run_002_hold", 0, 0, 2, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0); check_output("door_pause", 0, 0, 2, 0, 0, 1);
    apply_stimulus(0, 0, 1, 0, 1); check_output("resume", 0, 0, 2, 1, 0, 1);
    idle_cycles(1); check_output("resume_001", 0, 0, 1, 1, 0, 1);
    idle_cycles(4); check_output("done_enter", 0, 0, 0, 0, 1, 0);
    idle_cycles(11); check_output("done_last", 0, 0, 0, 0, 1, 0);
    idle_cycles(1); check_output("done_exit", 0, 0, 0, 0, 0, 0);

    // Stop beats start in RUN
    press_key(4'd5);
    apply_stimulus(0, 0, 1, 0, 1); check_output("run_005", 0, 0, 5, 1, 0, 1);
    apply_stimulus(0, 0, 1, 1, 1); check_output("stop_start_pause", 0, 0, 5, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1); check_output("pause_stop_idle", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN
    press_key(4'd3); press_key(4'd4); press_key(4'd5);
    check_output("entry_345", 3, 4, 5, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1); check_output("run_345", 3, 4, 5, 1, 0, 1);
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 0, 0, 0, 0, 0, 0);
    next_cycle();
    rst_n = 1'b1;
    apply_stimulus(0, 0, 1, 0, 1); check_output("start_after_reset", 0, 0, 0, 0, 0, 0);

    // Stop in DONE returns to IDLE at once
    press_key(4'd1);
    apply_stimulus(0, 0, 1, 0, 1);
    idle_cycles(4); check_output("done_001", 0, 0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 1); check_output("done_stop", 0, 0, 0, 0, 0, 0);

    idle_cycles(3);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
